// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM state encoding
// and the largest legal BCD digit value.
package bcd_to_bin_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    function automatic logic digit_bad(input logic [3:0] dig);
        return dig > DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_sub3.sv
// Per-digit correction for reverse double-dabble: undo the add-3 step of the
// binary-to-BCD path (8..12 -> 5..9, unreachable codes 13..15 -> 0).
module bcd_to_bin_seq_sub3 (
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);

    always_comb begin
        // NOTE: a default before the branches means every path assigns o_dig, so no latch is inferred.
        o_dig = 4'd0;
        if (i_dig < 4'd8) begin
            o_dig = i_dig;
        end else if (i_dig <= 4'd12) begin
            o_dig = i_dig - 4'd3;
        end
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: shifts the BCD value right one bit per
// cycle into the binary field, correcting each digit >=8 by subtracting 3.
import bcd_to_bin_seq_pkg::*;

module bcd_to_bin_seq #(
    parameter int NDIG  = 3,
    parameter int BIN_W = 10,
    parameter int CNT_W = 4
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic                busy,
    output logic                done,
    output logic [BIN_W-1:0]    bin_out,
    output logic                err,
    output logic                ovf
);

    localparam int SR_W = 4*NDIG + BIN_W;

    state_t            r_state;
    logic [SR_W-1:0]   r_sreg;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err_pend;

    logic [SR_W-1:0]   w_shift;
    logic [SR_W-1:0]   w_next;
    logic              w_bad;

    assign w_shift              = r_sreg >> 1;
    assign w_next[BIN_W-1:0]    = w_shift[BIN_W-1:0];

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_to_bin_seq_sub3 u_sub3 (
            .i_dig (w_shift[BIN_W+4*g +: 4]),
            .o_dig (w_next[BIN_W+4*g +: 4])
        );
    end

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (digit_bad(bcd_in[4*i +: 4])) begin
                w_bad = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sreg     <= '0;
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bin_out    <= '0;
            err        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt <= '0;
                        if (w_bad) begin
                            // Illegal digit: skip the shift, report a zero result.
                            r_sreg     <= '0;
                            r_err_pend <= 1'b1;
                            r_state    <= FIN;
                        end else begin
                            r_sreg     <= {bcd_in, {BIN_W{1'b0}}};
                            r_err_pend <= 1'b0;
                            busy       <= 1'b1;
                            r_state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_sreg <= w_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(BIN_W-1)) begin
                        busy    <= 1'b0;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    bin_out <= r_sreg[BIN_W-1:0];
                    // Any BCD residue left after BIN_W shifts means the value exceeded BIN_W bits.
                    ovf     <= |r_sreg[SR_W-1:BIN_W];
                    err     <= r_err_pend;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: latency, error path, ignored starts,
// reset abort, overflow on a narrow instance and a full 0..999 sweep.
module tb_bcd_to_bin_seq;
    import bcd_to_bin_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [11:0] bcd_a, bcd_b;
    logic        busy_a, done_a, err_a, ovf_a;
    logic        busy_b, done_b, err_b, ovf_b;
    logic [9:0]  bin_a;
    logic [7:0]  bin_b;

    int n_pass  = 0;
    int n_total = 0;
    int done_seen_a = 0;
    int lat, busy_cnt, d0;

    always #5 clk = ~clk;

    always @(posedge clk) if (done_a) done_seen_a++;

    bcd_to_bin_seq #(.NDIG(3), .BIN_W(10), .CNT_W(4)) u_dut_a (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start_a),
        .bcd_in   (bcd_a),
        .busy     (busy_a),
        .done     (done_a),
        .bin_out  (bin_a),
        .err      (err_a),
        .ovf      (ovf_a)
    );

    bcd_to_bin_seq #(.NDIG(3), .BIN_W(8), .CNT_W(4)) u_dut_b (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start_b),
        .bcd_in   (bcd_b),
        .busy     (busy_b),
        .done     (done_b),
        .bin_out  (bin_b),
        .err      (err_b),
        .ovf      (ovf_b)
    );

    // Called at a negedge; returns at the negedge where done is seen high.
    // lat counts edges after the accepting edge k; -1 means timeout.
    task automatic run_a(input logic [11:0] v);
        start_a = 1'b1;
        bcd_a   = v;
        @(posedge clk);
        @(negedge clk);
        start_a  = 1'b0;
        bcd_a    = 12'hFFF;
        lat      = -1;
        busy_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (done_a) begin
                lat = n;
                break;
            end
            if (busy_a) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_b(input logic [11:0] v);
        start_b = 1'b1;
        bcd_b   = v;
        @(posedge clk);
        @(negedge clk);
        start_b  = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (done_b) begin
                lat = n;
                break;
            end
            if (busy_b) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        bcd_a   = 12'h000;
        bcd_b   = 12'h000;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy_a, done_a, bin_a, err_a, ovf_a} !== 14'd0) begin
            $display("FAIL reset_a: got busy=%b done=%b bin=%0d err=%b ovf=%b, want all 0",
                     busy_a, done_a, bin_a, err_a, ovf_a);
        end else n_pass++;
        n_total++;
        if ({busy_b, done_b, bin_b, err_b, ovf_b} !== 12'd0) begin
            $display("FAIL reset_b: got busy=%b done=%b bin=%0d err=%b ovf=%b, want all 0",
                     busy_b, done_b, bin_b, err_b, ovf_b);
        end else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_a(12'h255);
        n_total++;
        if (lat !== 11 || busy_cnt !== 10) begin
            $display("FAIL lat_255: got lat=%0d busy=%0d, want lat=11 busy=10", lat, busy_cnt);
        end else n_pass++;
        n_total++;
        if (bin_a !== 10'd255 || err_a !== 1'b0 || ovf_a !== 1'b0) begin
            $display("FAIL val_255: got bin=%0d err=%b ovf=%b, want 255 0 0", bin_a, err_a, ovf_a);
        end else n_pass++;

        run_a(12'h999);
        n_total++;
        if (lat !== 11 || bin_a !== 10'h3E7 || ovf_a !== 1'b0) begin
            $display("FAIL val_999: got lat=%0d bin=%h ovf=%b, want 11 3e7 0", lat, bin_a, ovf_a);
        end else n_pass++;

        run_a(12'h000);
        n_total++;
        if (lat !== 11 || bin_a !== 10'd0 || ovf_a !== 1'b0) begin
            $display("FAIL val_000: got lat=%0d bin=%0d ovf=%b, want 11 0 0", lat, bin_a, ovf_a);
        end else n_pass++;
    endtask

    task automatic test_error();
        run_a(12'h0A5);
        n_total++;
        if (lat !== 1 || busy_cnt !== 0) begin
            $display("FAIL err_lat: got lat=%0d busy=%0d, want lat=1 busy=0", lat, busy_cnt);
        end else n_pass++;
        n_total++;
        if (err_a !== 1'b1 || bin_a !== 10'd0 || ovf_a !== 1'b0) begin
            $display("FAIL err_val: got err=%b bin=%0d ovf=%b, want 1 0 0", err_a, bin_a, ovf_a);
        end else n_pass++;

        run_a(12'h123);
        n_total++;
        if (lat !== 11 || err_a !== 1'b0 || bin_a !== 10'd123) begin
            $display("FAIL after_err: got lat=%0d err=%b bin=%0d, want 11 0 123", lat, err_a, bin_a);
        end else n_pass++;
    endtask

    task automatic test_ignore_start();
        @(negedge clk);
        d0      = done_seen_a;
        start_a = 1'b1;
        bcd_a   = 12'h042;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        start_a = 1'b1;
        bcd_a   = 12'h777;
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        n_total++;
        if (bin_a !== 10'd42 || err_a !== 1'b0) begin
            $display("FAIL ignore_val: got bin=%0d err=%b, want 42 0", bin_a, err_a);
        end else n_pass++;
        n_total++;
        if (done_seen_a - d0 !== 1) begin
            $display("FAIL ignore_done: got %0d done pulses, want 1", done_seen_a - d0);
        end else n_pass++;
    endtask

    task automatic test_reset_abort();
        start_a = 1'b1;
        bcd_a   = 12'h500;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        d0    = done_seen_a;
        @(negedge clk);
        n_total++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || bin_a !== 10'd0 || err_a !== 1'b0) begin
            $display("FAIL abort_state: got busy=%b done=%b bin=%0d err=%b, want 0 0 0 0",
                     busy_a, done_a, bin_a, err_a);
        end else n_pass++;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_total++;
        if (done_seen_a - d0 !== 0 || bin_a !== 10'd0) begin
            $display("FAIL abort_quiet: got %0d done pulses bin=%0d, want 0 and 0",
                     done_seen_a - d0, bin_a);
        end else n_pass++;

        run_a(12'h500);
        n_total++;
        if (lat !== 11 || bin_a !== 10'd500) begin
            $display("FAIL after_abort: got lat=%0d bin=%0d, want 11 500", lat, bin_a);
        end else n_pass++;
    endtask

    task automatic test_overflow();
        run_b(12'h300);
        n_total++;
        if (lat !== 9 || busy_cnt !== 8) begin
            $display("FAIL ovf_lat: got lat=%0d busy=%0d, want lat=9 busy=8", lat, busy_cnt);
        end else n_pass++;
        n_total++;
        if (bin_b !== 8'd44 || ovf_b !== 1'b1 || err_b !== 1'b0) begin
            $display("FAIL ovf_300: got bin=%0d ovf=%b err=%b, want 44 1 0", bin_b, ovf_b, err_b);
        end else n_pass++;

        run_b(12'h255);
        n_total++;
        if (bin_b !== 8'd255 || ovf_b !== 1'b0) begin
            $display("FAIL ovf_255: got bin=%0d ovf=%b, want 255 0", bin_b, ovf_b);
        end else n_pass++;

        run_b(12'h256);
        n_total++;
        if (bin_b !== 8'd0 || ovf_b !== 1'b1) begin
            $display("FAIL ovf_256: got bin=%0d ovf=%b, want 0 1", bin_b, ovf_b);
        end else n_pass++;
    endtask

    // Back-to-back sweep: each start is driven in the cycle done is seen.
    task automatic test_back_to_back();
        logic [11:0] v_bcd;
        logic        exp_err;
        @(negedge clk);
        for (int v = 0; v < 1000; v++) begin
            v_bcd   = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            exp_err = 1'b0;
            for (int d = 0; d < 3; d++) begin
                if (4'((v_bcd >> (4*d)) & 12'hF) > DIGIT_MAX) exp_err = 1'b1;
            end
            run_a(v_bcd);
            n_total++;
            if (lat !== 11 || bin_a !== 10'(v) || err_a !== exp_err || ovf_a !== 1'b0) begin
                $display("FAIL sweep_%0d: got lat=%0d bin=%0d err=%b ovf=%b, want 11 %0d %b 0",
                         v, lat, bin_a, err_a, ovf_a, v, exp_err);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_ignore_start();
        test_reset_abort();
        test_overflow();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter using reverse double-dabble: shift right one bit per cycle, then subtract 3 from every BCD digit that is ≥8.
- It is the inverse path of the existing combinational binary-to-BCD display chain.
- It takes decimal values entered on switches as BCD digits and returns the binary value for the adder datapath and for LED display.
- Single clock domain with a start/done handshake.

Parameters:
- NDIG, 3, number of BCD input digits (BCD width = 4*NDIG).
- BIN_W, 10, binary result width and number of shift iterations. The default covers 0..999.
- CNT_W, 4, iteration counter width. Must satisfy 2^CNT_W > BIN_W.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request. Sampled only in IDLE.
- bcd_in  input  4*NDIG  BCD digits, digit 0 in [3:0]. Sampled on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when bin_out, err and ovf are valid.
- bin_out  output  BIN_W  converted value. Held until the next done.
- err  output  1  an input digit was >9. Held with bin_out.
- ovf  output  1  the value does not fit in BIN_W bits. Held with bin_out.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - busy=0, done=0, bin_out=0, err=0, ovf=0.
  - Shift register and counter are cleared.
  - Reset asserted mid-conversion aborts it: no done pulse, outputs return to 0.
- State IDLE:
  - start=1 with all digits ≤9: load sreg = {bcd_in, BIN_W'b0}, cnt=0, go to SHIFT.
  - start=1 with any digit >9: go to FIN with err flagged and the result forced to 0. The shift is skipped.
- State SHIFT (one iteration per cycle):
  - t = sreg >> 1 (logical shift, MSB filled with 0).
  - Each 4-bit digit field of t[4*NDIG+BIN_W-1:BIN_W]: if ≥8, subtract 3; otherwise unchanged.
  - sreg ← result; cnt ← cnt+1.
  - When cnt reaches BIN_W-1, go to FIN. This gives exactly BIN_W iterations.
- State FIN (exactly one cycle):
  - done=1, busy=0.
  - bin_out ← sreg[BIN_W-1:0].
  - ovf ← (BCD field of sreg ≠ 0), i.e. residue remains.
  - err as set at start.
  - Next state is IDLE.
- Latency: start accepted at edge k → done high in cycle k+BIN_W+1 (k+11 by default). The error path gives done at k+1.
- start while busy or in FIN: ignored, not queued.
- Back-to-back: start may be asserted in the cycle after done. Minimum period is BIN_W+2 cycles.
- bin_out/err/ovf change only in FIN or on reset. They are stable between done pulses.
- bcd_in may change freely after acceptance.

Decomposition:
- Shared header, included by both RTL and bench:
  - State encoding localparams IDLE=2'd0, SHIFT=2'd1, FIN=2'd2.
  - DIGIT_MAX=4'd9.
- Sub-module sub3:
  - 4-bit combinational lookup, the inverse of the existing add3 correction: in≥8 → in-3, else in.
  - in 8..12 → 5..9. Values above 12 cannot occur for valid input; map them to 0.
  - Instantiated NDIG times via generate over the digit fields.

Test Plan:
- Reset, then bcd_in=12'h255 with a start pulse → busy for 10 cycles, done in cycle k+11, bin_out=10'd255, err=0, ovf=0.
- bcd_in=12'h999 → bin_out=10'h3E7. bcd_in=12'h000 → bin_out=0. Both must meet the same latency.
- bcd_in=12'h0A5 (digit 1 = 0xA) → done at k+1, err=1, bin_out=0. A following valid start of 12'h123 → bin_out=123, err=0.
- start re-pulsed at k+3 with 12'h777 during the 12'h042 conversion → ignored, bin_out=42, exactly one done pulse.
- reset asserted at k+5 during the 12'h500 conversion → next cycle busy=0, done never pulses, bin_out=0. A new start of 12'h500 → 500.
- Overflow: NDIG=3, BIN_W=8, bcd_in=12'h300 → ovf=1 and bin_out=300 mod 256=44. Also sweep all 0..999 against a reference model, with starts issued on the cycle after each done.
